// File: rtl/xor_stream_unit.sv
// -----------------------------------------------------------------------------
// xor_stream_unit
//
// Streaming bitwise unit with a single registered output stage. Each accepted
// input beat is combined as A^B (XOR), ~(A^B) (XNOR) or folded into a running
// XOR accumulator that emits one word per packet (ACCUM). The result is held
// in an output register together with its reduction-XOR parity.
//
// Handshake (both sides): a beat moves on a rising edge where valid and ready
// are both 1. valid must not depend on ready; once raised, the producer holds
// valid and its payload until the transfer. in_ready is derived only from
// the output register occupancy and out_ready, so a full output register
// that is being drained this cycle can accept a new beat with no bubble.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     unit accepts the input beat this cycle
//   in_a, in_b   operands (WIDTH bits)
//   in_last      final beat of an ACCUM packet (ignored in other modes)
//   mode         00 XOR, 01 ACCUM, 10 XNOR, 11 same as XOR
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_data     result word (WIDTH bits)
//   out_parity   XOR of all bits of out_data
//   dbg_state_o  accumulator FSM state (0 = IDLE, 1 = ACC)
// -----------------------------------------------------------------------------
module xor_stream_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             dbg_state_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_XOR   = 2'b00;
    localparam logic [1:0] MODE_ACCUM = 2'b01;
    localparam logic [1:0] MODE_XNOR  = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_parity_q, out_parity_d;

    // Result produced by the beat accepted this cycle, if any.
    logic             produce;
    logic [WIDTH-1:0] result;

    logic             accept;
    logic [WIDTH-1:0] ab_xor;
    logic [WIDTH-1:0] acc_base;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign ab_xor      = in_a ^ in_b;
    // A packet started in IDLE folds onto zero, one continued in ACC onto acc.
    assign acc_base    = (state_q == S_ACC) ? acc_q : '0;

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_parity  = out_parity_q;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: accumulator FSM and the result of the accepted beat
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        produce = 1'b0;
        result  = '0;

        if (accept) begin
            case (mode)
                MODE_ACCUM: begin
                    if (in_last) begin
                        produce = 1'b1;
                        result  = acc_base ^ ab_xor;
                        acc_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        acc_d   = acc_base ^ ab_xor;
                        state_d = S_ACC;
                    end
                end
                MODE_XNOR: begin
                    // Any non-ACCUM beat abandons a partial packet.
                    produce = 1'b1;
                    result  = ~ab_xor;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    // MODE_XOR and the reserved encoding 11.
                    produce = 1'b1;
                    result  = ab_xor;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register next-state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;

        if (produce) begin
            // Also covers drain + load in the same cycle: valid stays high.
            out_valid_d  = 1'b1;
            out_data_d   = result;
            out_parity_d = ^result;
        end else if (out_valid_q && out_ready) begin
            // Data is left in place; only valid drops after the transfer.
            out_valid_d  = 1'b0;
        end
    end

    // Unused-in-other-modes marker keeps MODE_XOR referenced for readers.
    logic unused_mode_xor;
    assign unused_mode_xor = (mode == MODE_XOR);

endmodule

// File: tb/tb_xor_stream_unit.sv
// -----------------------------------------------------------------------------
// Directed testbench for xor_stream_unit (WIDTH = 8).
// Inputs are driven 1 ns after a rising edge; outputs are sampled there too,
// so they show the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_xor_stream_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_last;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_parity;
  logic         dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  xor_stream_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called 1 ns after a rising edge; return 1 ns after the next)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic last);
    mode     = m;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    #1;
    check("send_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] bp_a[4];
  int           idx;
  int           n_out;
  int           last_xfer;
  logic         accepted;

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b1;
    bp_a[0] = 8'h11; bp_a[1] = 8'h22; bp_a[2] = 8'h33; bp_a[3] = 8'h44;

    // Reset: asserted away from any clock edge, outputs clear immediately.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid",  out_valid,  1'b0);
    check("rst_data",   out_data,   8'h00);
    check("rst_parity", out_parity, 1'b0);
    check("rst_state",  dbg_state,  1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_ready", in_ready, 1'b1);

    // XOR, 1-cycle latency.
    send(2'b00, 8'hA5, 8'h0F, 1'b0);
    check("xor_valid",  out_valid,  1'b1);
    check("xor_data",   out_data,   8'hAA);
    check("xor_parity", out_parity, 1'b0);
    step();
    check("xor_drained", out_valid, 1'b0);

    // XNOR back-to-back (no bubble between results).
    send(2'b10, 8'h00, 8'h00, 1'b0);
    check("xnor0_data",   out_data,   8'hFF);
    check("xnor0_parity", out_parity, 1'b0);
    send(2'b10, 8'h01, 8'h00, 1'b0);
    check("xnor1_valid",  out_valid,  1'b1);
    check("xnor1_data",   out_data,   8'hFE);
    check("xnor1_parity", out_parity, 1'b1);

    // Reserved mode 11 acts as XOR; zero result has zero parity.
    send(2'b11, 8'h3C, 8'h0F, 1'b1);
    check("m11_data",   out_data,   8'h33);
    send(2'b00, 8'h5A, 8'h5A, 1'b0);
    check("zero_data",   out_data,   8'h00);
    check("zero_parity", out_parity, 1'b0);
    step();

    // ACCUM packet of three beats.
    send(2'b01, 8'h01, 8'h02, 1'b0);
    check("acc1_novalid", out_valid, 1'b0);
    check("acc1_state",   dbg_state, 1'b1);
    send(2'b01, 8'h04, 8'h00, 1'b0);
    check("acc2_novalid", out_valid, 1'b0);
    send(2'b01, 8'h80, 8'h10, 1'b1);
    check("acc3_valid",  out_valid,  1'b1);
    check("acc3_data",   out_data,   8'h97);
    check("acc3_parity", out_parity, 1'b1);
    check("acc3_state",  dbg_state,  1'b0);
    step();
    check("acc_drained", out_valid, 1'b0);

    // A beat with in_valid = 0 changes nothing.
    mode = 2'b01; in_a = 8'hFF; in_b = 8'h00; in_last = 1'b1; in_valid = 1'b0;
    step();
    check("novalid_out",   out_valid, 1'b0);
    check("novalid_state", dbg_state, 1'b0);
    check("novalid_data",  out_data,  8'h97);

    // Back-pressure: 4 XOR beats, out_ready low for cycles 1..3.
    idx = 0; n_out = 0; last_xfer = -1;
    exp_q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (idx < 4) begin
        in_valid = 1'b1; mode = 2'b00; in_a = bp_a[idx]; in_b = 8'h00; in_last = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        check("bp_stall_ready", in_ready,  1'b0);
        check("bp_stall_valid", out_valid, 1'b1);
        check("bp_stall_data",  out_data,  8'h11);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected", out_valid, 1'b0);
        end else begin
          check("bp_data", out_data, exp_q.pop_front());
          n_out++;
          last_xfer = cyc;
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        exp_q.push_back(bp_a[idx] ^ 8'h00);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count",     n_out,        4);
    check("bp_last_xfer", last_xfer,    7);
    check("bp_queue",     exp_q.size(), 0);
    check("bp_accepted",  idx,          4);

    // Reset mid-packet discards the partial accumulation.
    send(2'b01, 8'hAA, 8'h00, 1'b0);
    send(2'b01, 8'h55, 8'h00, 1'b0);
    check("mid_state", dbg_state, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  out_valid,  1'b0);
    check("mid_rst_data",   out_data,   8'h00);
    check("mid_rst_parity", out_parity, 1'b0);
    check("mid_rst_state",  dbg_state,  1'b0);
    #1 rst_n = 1'b1;
    step();
    send(2'b01, 8'h33, 8'h00, 1'b1);
    check("mid_post_valid", out_valid, 1'b1);
    check("mid_post_data",  out_data,  8'h33);
    step();

    // Mode switch mid-packet.
    send(2'b01, 8'hF0, 8'h00, 1'b0);
    send(2'b00, 8'h0C, 8'h03, 1'b0);
    check("sw_data",  out_data,  8'h0F);
    check("sw_state", dbg_state, 1'b0);
    send(2'b01, 8'h01, 8'h00, 1'b1);
    check("sw_next_data",   out_data,   8'h01);
    check("sw_next_parity", out_parity, 1'b1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/xor_stream_unit.md
XOR_STREAM_UNIT -- requirements
Module: xor_stream_unit

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits (legal values 1 to 64).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  input beat valid.
REQ-005 in_ready  output  1  unit accepts the input beat this cycle.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 in_last  input  1  final beat of an accumulation packet; ignored in non-accumulate modes.
REQ-009 mode  input  2  operation select: 00 XOR, 01 ACCUM, 10 XNOR, 11 reserved.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  result word.
REQ-013 out_parity  output  1  reduction XOR of out_data.

Function
REQ-014 An input beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-015 An output is transferred when out_valid and out_ready are both 1 on a rising edge.
REQ-016 in_ready = !out_valid || out_ready.
- Combinational from the output-register state and out_ready only.
- Never depends on in_valid.
REQ-017 Mode 00, XOR:
- Each accepted beat loads out_data = in_a ^ in_b on the next edge and sets out_valid.
- Latency is 1 cycle.
REQ-018 Mode 10, XNOR:
- Each accepted beat loads out_data = ~(in_a ^ in_b) on the next edge and sets out_valid.
- Latency is 1 cycle.
REQ-019 Mode 11 behaves exactly as mode 00.
REQ-020 Mode 01, ACCUM, uses an internal WIDTH-bit accumulator acc and the states IDLE and ACC.
- IDLE, accepted beat with in_last = 0: acc <= in_a ^ in_b; go to ACC; no output.
- IDLE, accepted beat with in_last = 1: out_data <= in_a ^ in_b; out_valid set; stay in IDLE.
- ACC, accepted beat with in_last = 0: acc <= acc ^ in_a ^ in_b; no output.
- ACC, accepted beat with in_last = 1: out_data <= acc ^ in_a ^ in_b; out_valid set; acc cleared; go to IDLE.
REQ-021 Mode is sampled on every accepted beat.
- If an accepted beat in state ACC carries a mode other than 01, the partial packet is discarded: acc is cleared and the state goes to IDLE.
- That beat is then processed in its own mode in the same cycle.
REQ-022 out_data and out_parity hold stable while out_valid = 1 and out_ready = 0.
REQ-023 A transfer and an acceptance in the same cycle:
- If the accepted beat produces a result, the output register loads the new result and out_valid stays 1. There is no bubble.
- Otherwise out_valid clears.
REQ-024 out_parity is registered together with out_data.
- It always equals the XOR of all bits of out_data.
- It is 0 when out_data = 0.
REQ-025 In-packet beats (ACCUM with in_last = 0) still require in_ready = 1 to be accepted.
REQ-026 Beats presented with in_valid = 0 have no effect on acc, state or outputs, whatever in_a, in_b, mode and in_last are.

Reset
REQ-027 Assertion of rst_n = 0 immediately, without a clock edge, sets:
- out_valid = 0, out_data = 0, out_parity = 0;
- acc = 0 and state = IDLE.
REQ-028 Reset asserted mid-packet discards the partial accumulation; no result for that packet is ever produced.
REQ-029 After rst_n deasserts, in_ready = 1 in the first cycle.

Verification
REQ-030 WIDTH = 8, mode 00, a = 0xA5, b = 0x0F, out_ready = 1 -> next cycle out_valid = 1, out_data = 0xAA, out_parity = 0.
REQ-031 Mode 10, a = 0x00, b = 0x00 -> out_data = 0xFF, out_parity = 0.
- Then the same operands with a = 0x01 -> out_data = 0xFE, out_parity = 1.
REQ-032 Mode 01, three beats (a, b) = (0x01, 0x02), (0x04, 0x00), (0x80, 0x10) with in_last on beat 3:
- A single output 0x97 with parity 1, one cycle after beat 3.
- No output after beats 1 and 2.
REQ-033 Back-pressure: mode 00 stream of 4 beats, with out_ready held at 0 for 3 cycles after the first result:
- out_data is held at the first result and in_ready = 0 during the stall.
- All 4 results emerge in order with none lost or duplicated.
- Throughput is one per cycle once out_ready = 1.
REQ-034 Reset mid-packet: mode 01, two non-last beats, rst_n pulsed low asynchronously, then one beat with in_last = 1, a = 0x33, b = 0x00:
- Outputs are 0 during reset.
- The post-reset result is 0x33.
REQ-035 Mode switch mid-packet: mode 01 beat (0xF0, 0x00) with in_last = 0, then mode 00 beat (0x0C, 0x03):
- Output is 0x0F.
- The next mode 01 packet starts from acc = 0.
